// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch stage. Reads instruction memory at the
// current PC, advances the PC on each hit, and buffers {pc, instr} pairs in
// a small FIFO toward decode. Handles redirect (flush) and halt-word stop.
module fetch_queue #(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] cpc,
  output logic        pcEn,
  input  logic        flush,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        ihit,
  input  logic [31:0] iload,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_npc,
  output logic        fetch_halted
);

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = AW + 1;

  typedef enum logic {FETCH, HALTED} state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [31:0]      pc_mem    [DEPTH];
  logic [31:0]      instr_mem [DEPTH];

  logic full, accept, pop;

  // Full uses the registered count only, so decode's ready never reaches iREN.
  assign full      = (count == CNT_W'(DEPTH));
  assign iaddr     = cpc;
  assign iREN      = (state == FETCH) & ~full & ~flush & ~RST;
  assign accept    = iREN & ihit;
  assign pcEn      = (accept | flush) & ~RST;
  assign out_valid = (count != '0) & ~RST;
  assign pop       = out_valid & out_ready;
  assign fetch_halted = (state == HALTED) & ~RST;

  assign out_pc    = pc_mem[rd_ptr];
  assign out_instr = instr_mem[rd_ptr];
  assign out_npc   = out_pc + 32'd4;

  // Control: fetch/halt state, occupancy and pointers; flush discards all.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= FETCH;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      state  <= FETCH;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // The halt word itself is still queued and delivered to decode.
      if (accept && (iload == HALT_WORD)) state <= HALTED;
    end
  end

  // Entry storage; contents are don't-care after reset, so no reset here.
  always_ff @(posedge CLK) begin
    if (accept) begin
      pc_mem[wr_ptr]    <= cpc;
      instr_mem[wr_ptr] <= iload;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenarios plus randomized traffic, all checked
// against a queue-based reference model that also plays the pc block.
module tb_fetch_queue;

  localparam int          DEPTH = 2;
  localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

  logic        CLK, RST, flush, ihit, out_ready;
  logic [31:0] cpc, iload;
  logic        pcEn, iREN, out_valid, fetch_halted;
  logic [31:0] iaddr, out_instr, out_pc, out_npc;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [63:0] m_q[$];
  bit          m_halted = 0;
  logic [31:0] m_cpc    = '0;
  logic [31:0] a_tgt;
  // expectations for the current cycle
  logic        e_iren, e_acc, e_pcen, e_valid, e_halted;
  logic [31:0] e_pc, e_instr;

  fetch_queue #(.DEPTH(DEPTH), .HALT_WORD(HALT)) dut (
    .CLK(CLK), .RST(RST), .cpc(cpc), .pcEn(pcEn), .flush(flush),
    .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_npc(out_npc), .fetch_halted(fetch_halted)
  );

  initial CLK = 0;
  always #5 CLK = ~CLK;

  // drive one cycle's inputs, derive expectations, move to the sampling point
  task automatic apply(input logic rst, input logic fl, input logic hit,
                       input logic rdy, input logic [31:0] word,
                       input logic [31:0] tgt);
    RST = rst; flush = fl; ihit = hit; out_ready = rdy; iload = word;
    cpc = m_cpc; a_tgt = tgt;
    e_iren   = !rst && !m_halted && (m_q.size() < DEPTH) && !fl;
    e_acc    = e_iren && hit;
    e_pcen   = !rst && (e_acc || fl);
    e_valid  = !rst && (m_q.size() != 0);
    e_halted = !rst && m_halted;
    e_pc     = (m_q.size() != 0) ? m_q[0][63:32] : 32'h0;
    e_instr  = (m_q.size() != 0) ? m_q[0][31:0]  : 32'h0;
    @(negedge CLK);
  endtask

  // clock edge, then update model (FIFO, halt flag, pc block)
  task automatic adv();
    @(posedge CLK); #1;
    if (RST) begin
      m_q.delete(); m_halted = 0; m_cpc = a_tgt;
    end else if (flush) begin
      m_q.delete(); m_halted = 0; m_cpc = a_tgt;
    end else begin
      if (e_valid && out_ready) void'(m_q.pop_front());
      if (e_acc) begin
        m_q.push_back({m_cpc, iload});
        if (iload == HALT) m_halted = 1;
        m_cpc = m_cpc + 32'd4;
      end
    end
  endtask

  task automatic do_reset(input logic [31:0] pc);
    apply(1, 0, 0, 0, 32'h0, pc);
    adv();
  endtask

  task automatic test_reset();
    apply(1, 0, 1, 1, 32'h0, 32'h0);
    total++;
    if ({iREN, pcEn, out_valid, fetch_halted} !== 4'b0000) begin
      bad++; $display("FAIL reset_outputs got=%b want=0000", {iREN, pcEn, out_valid, fetch_halted});
    end
    adv();
    apply(0, 0, 0, 0, 32'h0, 32'h0);
    total++;
    if ({iREN, out_valid, fetch_halted} !== 3'b100) begin
      bad++; $display("FAIL post_reset got=%b want=100", {iREN, out_valid, fetch_halted});
    end
    adv();
  endtask

  task automatic test_stream();
    logic [31:0] words [3];
    words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33;
    do_reset(32'h0);
    for (int i = 0; i < 4; i++) begin
      apply(0, 0, (i < 3), 1, (i < 3) ? words[i] : 32'h0, 32'h0);
      if (i < 3) begin
        total++;
        if (pcEn !== 1'b1) begin bad++; $display("FAIL stream_pcen c%0d got=%b want=1", i, pcEn); end
      end
      if (i >= 1) begin
        total++;
        if ({out_valid, out_pc, out_npc, out_instr} !== {1'b1, 32'(4*(i-1)), 32'(4*i), words[i-1]}) begin
          bad++; $display("FAIL stream_head c%0d got=%b/%h/%h/%h want pc=%0h", i, out_valid, out_pc, out_npc, out_instr, 4*(i-1));
        end
      end
      adv();
    end
  endtask

  task automatic test_backpressure();
    do_reset(32'h0);
    for (int i = 0; i < 2; i++) begin
      apply(0, 0, 1, 0, 32'hA0 + i, 32'h0);
      total++;
      if (pcEn !== 1'b1) begin bad++; $display("FAIL bp_accept c%0d got=%b want=1", i, pcEn); end
      adv();
    end
    apply(0, 0, 1, 0, 32'hA2, 32'h0);
    total++;
    if ({iREN, pcEn, out_pc} !== {2'b00, 32'h0}) begin
      bad++; $display("FAIL bp_full got=%b%b/%h want=00/0", iREN, pcEn, out_pc);
    end
    adv();
    apply(0, 0, 1, 1, 32'hA2, 32'h0);
    total++;
    if (iREN !== 1'b0) begin bad++; $display("FAIL bp_full_pop got=%b want=0", iREN); end
    adv();
    apply(0, 0, 1, 0, 32'hA2, 32'h0);
    total++;
    if ({iREN, pcEn, iaddr, out_pc} !== {2'b11, 32'h8, 32'h4}) begin
      bad++; $display("FAIL bp_resume got=%b%b/%h/%h want=11/8/4", iREN, pcEn, iaddr, out_pc);
    end
    adv();
  endtask

  task automatic test_miss();
    do_reset(32'h40);
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 0, 1, 32'h0, 32'h0);
      total++;
      if ({iREN, pcEn, iaddr} !== {2'b10, 32'h40}) begin
        bad++; $display("FAIL miss_hold c%0d got=%b%b/%h want=10/40", i, iREN, pcEn, iaddr);
      end
      adv();
    end
    apply(0, 0, 1, 0, 32'h55, 32'h0);
    total++;
    if (pcEn !== 1'b1) begin bad++; $display("FAIL miss_hit got=%b want=1", pcEn); end
    adv();
    apply(0, 0, 0, 0, 32'h0, 32'h0);
    total++;
    if ({out_valid, out_pc, out_instr} !== {1'b1, 32'h40, 32'h55}) begin
      bad++; $display("FAIL miss_push got=%b/%h/%h want=1/40/55", out_valid, out_pc, out_instr);
    end
    adv();
  endtask

  task automatic test_flush();
    do_reset(32'h0);
    for (int i = 0; i < 2; i++) begin apply(0, 0, 1, 0, 32'hB0 + i, 32'h0); adv(); end
    apply(0, 1, 1, 0, 32'hB2, 32'h100);
    total++;
    if ({pcEn, iREN} !== 2'b10) begin bad++; $display("FAIL flush_cycle got=%b%b want=10", pcEn, iREN); end
    adv();
    apply(0, 0, 1, 0, 32'h77, 32'h0);
    total++;
    if ({out_valid, iaddr, pcEn} !== {1'b0, 32'h100, 1'b1}) begin
      bad++; $display("FAIL flush_after got=%b/%h/%b want=0/100/1", out_valid, iaddr, pcEn);
    end
    adv();
    apply(0, 0, 0, 0, 32'h0, 32'h0);
    total++;
    if ({out_pc, out_instr} !== {32'h100, 32'h77}) begin
      bad++; $display("FAIL flush_redirect got=%h/%h want=100/77", out_pc, out_instr);
    end
    adv();
  endtask

  task automatic test_halt();
    logic [31:0] words [3];
    words[0] = 32'h1; words[1] = 32'h2; words[2] = HALT;
    do_reset(32'h0);
    for (int i = 0; i < 3; i++) begin apply(0, 0, 1, 1, words[i], 32'h0); adv(); end
    apply(0, 0, 1, 0, 32'h3, 32'h0);
    total++;
    if ({out_valid, out_instr, out_pc, fetch_halted, iREN} !== {1'b1, HALT, 32'h8, 2'b10}) begin
      bad++; $display("FAIL halt_word got=%b/%h/%h/%b%b want=1/ffffffff/8/10", out_valid, out_instr, out_pc, fetch_halted, iREN);
    end
    adv();
    apply(0, 1, 0, 0, 32'h0, 32'h200);
    total++;
    if (pcEn !== 1'b1) begin bad++; $display("FAIL halt_flush got=%b want=1", pcEn); end
    adv();
    apply(0, 0, 0, 0, 32'h0, 32'h0);
    total++;
    if ({iREN, fetch_halted, iaddr} !== {2'b10, 32'h200}) begin
      bad++; $display("FAIL halt_resume got=%b%b/%h want=10/200", iREN, fetch_halted, iaddr);
    end
    adv();
  endtask

  task automatic test_mid_reset();
    do_reset(32'h0);
    for (int i = 0; i < 2; i++) begin apply(0, 0, 1, 0, 32'hC0 + i, 32'h0); adv(); end
    apply(1, 0, 1, 1, 32'hC2, 32'h0);
    total++;
    if ({out_valid, iREN, pcEn} !== 3'b000) begin
      bad++; $display("FAIL midrst_comb got=%b want=000", {out_valid, iREN, pcEn});
    end
    adv();
    apply(0, 0, 0, 0, 32'h0, 32'h0);
    total++;
    if ({out_valid, iREN} !== 2'b01) begin
      bad++; $display("FAIL midrst_empty got=%b want=01", {out_valid, iREN});
    end
    adv();
  endtask

  task automatic test_random();
    logic        r, f, h, d;
    logic [31:0] w, t;
    do_reset(32'h1000);
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 49) == 0);
      f = ($urandom_range(0, 11) == 0);
      h = ($urandom_range(0, 9) < 7);
      d = ($urandom_range(0, 9) < 6);
      w = ($urandom_range(0, 9) == 0) ? HALT : $urandom;
      t = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      apply(r, f, h, d, w, t);
      total++;
      if ({iREN, pcEn, out_valid, fetch_halted, iaddr} !== {e_iren, e_pcen, e_valid, e_halted, m_cpc}) begin
        bad++; $display("FAIL rand_ctrl c%0d got=%b%b%b%b/%h want=%b%b%b%b/%h", i,
          iREN, pcEn, out_valid, fetch_halted, iaddr, e_iren, e_pcen, e_valid, e_halted, m_cpc);
      end
      if (e_valid) begin
        total++;
        if ({out_pc, out_instr, out_npc} !== {e_pc, e_instr, e_pc + 32'd4}) begin
          bad++; $display("FAIL rand_head c%0d got=%h/%h/%h want=%h/%h/%h", i,
            out_pc, out_instr, out_npc, e_pc, e_instr, e_pc + 32'd4);
        end
      end
      adv();
    end
  endtask

  initial begin
    RST = 1; flush = 0; ihit = 0; out_ready = 0; cpc = 0; iload = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_miss();
    test_flush();
    test_halt();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch stage sitting directly downstream of the program counter block and upstream of decode. It issues instruction-memory reads at the current PC and advances the PC on each hit. Fetched words are buffered with their PC in a small FIFO that decouples fetch from a stalling decode stage. It also discards wrong-path words on a redirect and stops fetching after a halt word.

## Interface
Parameters:
- DEPTH, 2, FIFO entries; power of two, ≥2
- HALT_WORD, 32'hFFFFFFFF, instruction encoding that stops fetch

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  reset, synchronous, active-high
- cpc  in  32  current PC from pc block
- pcEn  out  1  PC advance/load enable to pc block
- flush  in  1  redirect from execute; pc block's pcSel already selects target
- iREN  out  1  instruction memory read enable
- iaddr  out  32  instruction memory address
- ihit  in  1  memory returns iload this cycle (combinational with iREN)
- iload  in  32  instruction word
- out_valid  out  1  head entry valid toward decode
- out_ready  in  1  decode accepts head this cycle
- out_instr  out  32  head instruction
- out_pc  out  32  head PC
- out_npc  out  32  head PC + 4
- fetch_halted  out  1  fetch stopped on HALT_WORD

## Operation
- State machine, two states: FETCH, HALTED. Reset → FETCH.
- FIFO of {pc, instr}; count in 0..DEPTH, wrapping read/write pointers of log2(DEPTH) bits.
- Outputs:
  - iaddr = cpc.
  - iREN = state==FETCH & count<DEPTH & ~flush & ~RST. Full is evaluated on registered count only; there is no path from out_ready to iREN.
  - accept = iREN & ihit; pushes {cpc, iload}.
  - pcEn = accept | flush, gated by ~RST.
  - pop = out_valid & out_ready.
  - out_valid = count!=0; out_* from the head entry; out_npc = out_pc + 32'd4, modulo 2^32.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- On accept with iload==HALT_WORD: state → HALTED. The halt word is still pushed and delivered to decode.
- HALTED: iREN=0 and fetch_halted=1. Left only by flush (→FETCH) or RST.
- flush, highest priority:
  - Next edge: count←0 and pointers←0; any same-cycle push and pop are ignored.
  - State→FETCH.
  - pcEn=1 so the pc block loads the redirect target.
  - iREN=0 in the flush cycle.
- flush is also honoured while the FIFO is empty or the block is HALTED.
- RST high: count=0, pointers=0, state FETCH.
  - Combinationally, iREN=0, pcEn=0, out_valid=0 and fetch_halted=0 for every cycle RST is high, including mid-request.
  - FIFO data contents are don't-care.

## Timing
- Fetch latency: the word hit in cycle N is visible at out_* in cycle N+1, when the FIFO was empty.
- Throughput: one accept per cycle while count<DEPTH and ihit=1. The PC advances in the same cycle.
- If ihit=0, iREN holds with iaddr unchanged until a hit arrives; pcEn stays 0.
- Full FIFO with pop in the same cycle: no fetch that cycle; fetch resumes the next cycle.
- Decode backpressure: out_* are stable while out_valid=1 and out_ready=0.
- First request after reset deassertion: same cycle.

## Test plan
- Streaming:
  - Stimulus: reset with cpc=0; ihit=1 every cycle; out_ready=1; words 0x11,0x22,0x33.
  - Response: out_pc 0,4,8 on consecutive cycles from cycle 1; out_npc 4,8,12; pcEn=1 each cycle.
- Backpressure:
  - Stimulus: out_ready=0 with ihit=1.
  - Response: after 2 accepts, iREN=0 and pcEn=0; out_pc holds 0. Raising out_ready pops one entry, and fetch resumes the next cycle at cpc=8.
- Miss:
  - Stimulus: ihit=0 for 3 cycles at cpc=0x40.
  - Response: iaddr=0x40 and iREN=1 throughout, pcEn=0; word pushed on the 4th cycle.
- Flush with 2 entries queued:
  - Stimulus: flush=1 for one cycle.
  - Response: pcEn=1 and iREN=0 that cycle; out_valid=0 next cycle; the next push carries the redirected cpc.
- Halt:
  - Stimulus: fetch 0xFFFFFFFF at pc 0x8.
  - Response: it appears at out_instr with out_pc=0x8; fetch_halted=1 and iREN=0 afterwards. A later flush restores iREN=1.
- Mid-stream reset:
  - Stimulus: RST=1 with 2 entries queued.
  - Response: out_valid, iREN and pcEn all read 0 in that cycle; count=0 after the edge.
